regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-bank write-port arbiter: clears every register after reset, then grants ALU and
// load-unit writebacks one per cycle with alternating priority on contention.
module regfile_write_arbiter #(
    parameter int N = 32,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [$clog2(N)-1:0] alu_rd,
    input  logic [W-1:0]         alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [$clog2(N)-1:0] mem_rd,
    input  logic [W-1:0]         mem_data,
    output logic                 mem_ready,
    output logic                 rf_we,
    output logic [$clog2(N)-1:0] rf_addr_rd,
    output logic [W-1:0]         rf_data_in,
    output logic                 init_done,
    output logic [15:0]          conflict_cnt
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_sweep_done, w_sweep_done_nxt;
    logic            r_last_mem, w_last_mem_nxt;
    logic [15:0]     r_conflict, w_conflict_nxt;
    logic            r_we, w_we_nxt;
    logic [AW-1:0]   r_addr, w_addr_nxt;
    logic [W-1:0]    r_data, w_data_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_CLEAR;
            r_cnt        <= '0;
            r_sweep_done <= 1'b0;
            r_last_mem   <= 1'b1;
            r_conflict   <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sweep_done <= w_sweep_done_nxt;
            r_last_mem   <= w_last_mem_nxt;
            r_conflict   <= w_conflict_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_sweep_done_nxt = r_sweep_done;
        w_last_mem_nxt   = r_last_mem;
        w_conflict_nxt   = r_conflict;
        w_we_nxt         = 1'b0;
        w_addr_nxt       = r_addr;
        w_data_nxt       = r_data;
        alu_ready        = 1'b0;
        mem_ready        = 1'b0;
        init_done        = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                // The last sweep write is still on the outputs when the done flag is seen,
                // so RUN begins only after that write has reached the bank.
                if (!r_sweep_done) begin
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = r_cnt;
                    w_data_nxt = '0;
                    if (r_cnt == LAST_ADDR) begin
                        w_sweep_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                init_done = 1'b1;
                alu_ready = alu_valid && (!mem_valid || r_last_mem);
                mem_ready = mem_valid && (!alu_valid || !r_last_mem);
                if (alu_ready) begin
                    w_last_mem_nxt = 1'b0;
                    w_we_nxt       = (alu_rd != '0);
                    w_addr_nxt     = alu_rd;
                    w_data_nxt     = alu_data;
                end else if (mem_ready) begin
                    w_last_mem_nxt = 1'b1;
                    w_we_nxt       = (mem_rd != '0);
                    w_addr_nxt     = mem_rd;
                    w_data_nxt     = mem_data;
                end
                if (alu_valid && mem_valid && (r_conflict != 16'hFFFF)) begin
                    w_conflict_nxt = r_conflict + 16'd1;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    assign rf_we        = r_we;
    assign rf_addr_rd   = r_addr;
    assign rf_data_in   = r_data;
    assign conflict_cnt = r_conflict;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus a randomized run checked against
// a register-bank model that applies the grant rules directly.
module tb_regfile_write_arbiter;
    localparam int N  = 32;
    localparam int W  = 32;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic [AW-1:0] alu_rd, mem_rd;
    logic [W-1:0]  alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          rf_we;
    logic [AW-1:0] rf_addr_rd;
    logic [W-1:0]  rf_data_in;
    logic          init_done;
    logic [15:0]   conflict_cnt;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_addr_rd(rf_addr_rd), .rf_data_in(rf_data_in),
        .init_done(init_done), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic go_run();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        total++;
        if (init_done !== 1'b1) begin
            bad++; $display("FAIL go_run_init_done got=%0b want=1", init_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = $urandom;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = $urandom;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({rf_we, rf_addr_rd, rf_data_in} !== '0) begin
            bad++; $display("FAIL reset_rf got=%0b/%0h/%0h want=0/0/0", rf_we, rf_addr_rd, rf_data_in);
        end
        total++;
        if ({alu_ready, mem_ready, init_done} !== 3'b000) begin
            bad++; $display("FAIL reset_ready_init got=%b want=000", {alu_ready, mem_ready, init_done});
        end
        total++;
        if (conflict_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_conflict got=%0d want=0", conflict_cnt);
        end
    endtask

    task automatic test_sweep();
        alu_rd = '0; mem_rd = '0;
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            total++;
            if (rf_we !== 1'b1 || rf_addr_rd !== AW'(i) || rf_data_in !== '0) begin
                bad++; $display("FAIL sweep_write got=%0b/%0d/%0h want=1/%0d/0", rf_we, rf_addr_rd, rf_data_in, i);
            end
            total++;
            if ({alu_ready, mem_ready, init_done} !== 3'b000) begin
                bad++; $display("FAIL sweep_ready_init got=%b want=000 at %0d", {alu_ready, mem_ready, init_done}, i);
            end
        end
        @(posedge clk); #1;
        total++;
        if (init_done !== 1'b1 || rf_we !== 1'b0) begin
            bad++; $display("FAIL sweep_end got=init%0b/we%0b want=init1/we0", init_done, rf_we);
        end
        drive_idle();
        total++;
        if (conflict_cnt !== 16'd0) begin
            bad++; $display("FAIL sweep_conflict got=%0d want=0", conflict_cnt);
        end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            bad++; $display("FAIL single_alu_ready got=%b want=10", {alu_ready, mem_ready});
        end
        @(posedge clk); #1;
        drive_idle();
        total++;
        if (rf_we !== 1'b1 || rf_addr_rd !== 5'd5 || rf_data_in !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_alu_write got=%0b/%0d/%0h want=1/5/deadbeef", rf_we, rf_addr_rd, rf_data_in);
        end
        @(posedge clk); #1;
        total++;
        if (rf_we !== 1'b0) begin
            bad++; $display("FAIL single_alu_idle got=%0b want=0", rf_we);
        end
    endtask

    task automatic test_contention();
        logic want_alu;
        go_run();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = $urandom;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = $urandom;
        for (int k = 0; k < 4; k++) begin
            want_alu = (k % 2 == 0);
            @(negedge clk);
            total++;
            if (alu_ready !== want_alu || mem_ready !== !want_alu) begin
                bad++; $display("FAIL contention_grant got=%b want=%b at %0d", {alu_ready, mem_ready}, {want_alu, !want_alu}, k);
            end
            @(posedge clk); #1;
            total++;
            if (rf_we !== 1'b1 || rf_addr_rd !== (want_alu ? 5'd1 : 5'd2) ||
                rf_data_in !== (want_alu ? alu_data : mem_data)) begin
                bad++; $display("FAIL contention_write got=%0b/%0d/%0h want=1/%0d/%0h", rf_we, rf_addr_rd, rf_data_in,
                                want_alu ? 1 : 2, want_alu ? alu_data : mem_data);
            end
            if (want_alu) alu_data = $urandom; else mem_data = $urandom;
        end
        drive_idle();
        total++;
        if (conflict_cnt !== 16'd4) begin
            bad++; $display("FAIL contention_count got=%0d want=4", conflict_cnt);
        end
    endtask

    task automatic test_same_rd();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'd1;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'd2;
        @(negedge clk);
        total++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            bad++; $display("FAIL same_rd_first got=%b want=10", {alu_ready, mem_ready});
        end
        @(posedge clk); #1;
        alu_valid = 1'b0;
        total++;
        if (rf_we !== 1'b1 || rf_addr_rd !== 5'd7 || rf_data_in !== 32'd1) begin
            bad++; $display("FAIL same_rd_write1 got=%0b/%0d/%0h want=1/7/1", rf_we, rf_addr_rd, rf_data_in);
        end
        @(negedge clk);
        total++;
        if ({alu_ready, mem_ready} !== 2'b01) begin
            bad++; $display("FAIL same_rd_second got=%b want=01", {alu_ready, mem_ready});
        end
        @(posedge clk); #1;
        drive_idle();
        total++;
        if (rf_we !== 1'b1 || rf_addr_rd !== 5'd7 || rf_data_in !== 32'd2) begin
            bad++; $display("FAIL same_rd_write2 got=%0b/%0d/%0h want=1/7/2", rf_we, rf_addr_rd, rf_data_in);
        end
        total++;
        if (conflict_cnt !== 16'd5) begin
            bad++; $display("FAIL same_rd_count got=%0d want=5", conflict_cnt);
        end
    endtask

    task automatic test_rd_zero();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
        @(negedge clk);
        total++;
        if ({alu_ready, mem_ready} !== 2'b01) begin
            bad++; $display("FAIL rd_zero_ready got=%b want=01", {alu_ready, mem_ready});
        end
        @(posedge clk); #1;
        drive_idle();
        total++;
        if (rf_we !== 1'b0) begin
            bad++; $display("FAIL rd_zero_we got=%0b want=0", rf_we);
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        logic leaked;
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (rf_we === 1'b1 && rf_addr_rd === 5'd10) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL mid_sweep_reach got=none want=addr10");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (rf_we !== 1'b0) begin
            bad++; $display("FAIL mid_sweep_discard got=%0b want=0", rf_we);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rf_we !== 1'b1 || rf_addr_rd !== 5'd0 || rf_data_in !== '0) begin
            bad++; $display("FAIL mid_sweep_restart got=%0b/%0d/%0h want=1/0/0", rf_we, rf_addr_rd, rf_data_in);
        end
        repeat (32) @(posedge clk);
        #1;
        total++;
        if (init_done !== 1'b1) begin
            bad++; $display("FAIL mid_sweep_done got=%0b want=1", init_done);
        end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h12345678;
        @(negedge clk);
        total++;
        if (alu_ready !== 1'b1) begin
            bad++; $display("FAIL mid_run_ready got=%0b want=1", alu_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        total++;
        if (rf_we !== 1'b0 || init_done !== 1'b0) begin
            bad++; $display("FAIL mid_run_discard got=we%0b/init%0b want=we0/init0", rf_we, init_done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rf_we !== 1'b1 || rf_addr_rd !== 5'd0 || rf_data_in !== '0) begin
            bad++; $display("FAIL mid_run_restart got=%0b/%0d/%0h want=1/0/0", rf_we, rf_addr_rd, rf_data_in);
        end
        leaked = 1'b0;
        for (int c = 0; c < 34; c++) begin
            @(posedge clk); #1;
            if (rf_we === 1'b1 && rf_data_in === 32'h12345678) leaked = 1'b1;
        end
        total++;
        if (leaked) begin
            bad++; $display("FAIL mid_run_leak got=write_seen want=none");
        end
    endtask

    task automatic test_random();
        logic [W-1:0]  mbank [N];
        logic [W-1:0]  dbank [N];
        logic          a_v, m_v, ea, em, last_mem, exp_we;
        logic [AW-1:0] a_rd, m_rd, exp_addr;
        logic [W-1:0]  a_d, m_d, exp_data;
        int            exp_conf;
        go_run();
        for (int i = 0; i < N; i++) begin mbank[i] = '0; dbank[i] = '0; end
        a_v = 1'b0; m_v = 1'b0; a_rd = '0; m_rd = '0; a_d = '0; m_d = '0;
        last_mem = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_conf = 0;
        for (int cyc = 0; cyc <= 500; cyc++) begin
            total++;
            if (rf_we !== exp_we || (exp_we && (rf_addr_rd !== exp_addr || rf_data_in !== exp_data))) begin
                bad++; $display("FAIL random_write got=%0b/%0d/%0h want=%0b/%0d/%0h cyc=%0d",
                                rf_we, rf_addr_rd, rf_data_in, exp_we, exp_addr, exp_data, cyc);
            end
            if (rf_we === 1'b1) dbank[rf_addr_rd] = rf_data_in;
            if (cyc == 500) break;
            if (!a_v && $urandom_range(0, 9) < 6) begin
                a_v = 1'b1; a_rd = AW'($urandom_range(0, N - 1)); a_d = $urandom;
            end
            if (!m_v && $urandom_range(0, 9) < 6) begin
                m_v = 1'b1; m_rd = AW'($urandom_range(0, N - 1)); m_d = $urandom;
            end
            alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
            mem_valid = m_v; mem_rd = m_rd; mem_data = m_d;
            @(negedge clk);
            ea = a_v && (!m_v || last_mem);
            em = m_v && !ea;
            total++;
            if (alu_ready !== ea || mem_ready !== em) begin
                bad++; $display("FAIL random_ready got=%b want=%b cyc=%0d", {alu_ready, mem_ready}, {ea, em}, cyc);
            end
            if (a_v && m_v && exp_conf < 65535) exp_conf++;
            exp_we = 1'b0;
            if (ea) begin
                exp_we = (a_rd != 0); exp_addr = a_rd; exp_data = a_d;
                if (a_rd != 0) mbank[a_rd] = a_d;
                last_mem = 1'b0; a_v = 1'b0;
            end else if (em) begin
                exp_we = (m_rd != 0); exp_addr = m_rd; exp_data = m_d;
                if (m_rd != 0) mbank[m_rd] = m_d;
                last_mem = 1'b1; m_v = 1'b0;
            end
            @(posedge clk); #1;
        end
        drive_idle();
        total++;
        if (int'(conflict_cnt) !== exp_conf) begin
            bad++; $display("FAIL random_conflict got=%0d want=%0d", conflict_cnt, exp_conf);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (dbank[i] !== mbank[i]) begin
                bad++; $display("FAIL random_bank[%0d] got=%0h want=%0h", i, dbank[i], mbank[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_sweep();
        test_single_alu();
        test_contention();
        test_same_rd();
        test_rd_zero();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
